mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum number of WAIT cycles before an error response.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have ports p<n>_valid_i, input, 1, request valid, for n = 0 and 1.
REQ-007 SHALL have ports p<n>_wr_rd_i, input, 1, 1 = write and 0 = read, for n = 0 and 1.
REQ-008 SHALL have ports p<n>_addr_i, input, ADDR_WIDTH, request address, for n = 0 and 1.
REQ-009 SHALL have ports p<n>_w_data_i, input, WIDTH, write data, for n = 0 and 1.
REQ-010 SHALL have ports p<n>_ready_o, output, 1, one-cycle completion pulse, for n = 0 and 1.
REQ-011 SHALL have ports p<n>_err_o, output, 1, timeout flag valid with ready, for n = 0 and 1.
REQ-012 SHALL have ports p<n>_r_data_o, output, WIDTH, read data valid with ready, for n = 0 and 1.
REQ-013 SHALL have ports mem_valid_o (output, 1), mem_wr_rd_o (output, 1), mem_addr_o (output, ADDR_WIDTH) and mem_w_data_o (output, WIDTH), the memory-side request.
REQ-014 SHALL have ports mem_r_data_i (input, WIDTH) and mem_ready_i (input, 1), the memory-side response.
REQ-015 SHALL have ports busy_o (output, 1), high when state is not IDLE, and grant_o (output, 1), the index of the current or last granted port.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, with every output driven from a register.
REQ-017 In IDLE with any p<n>_valid_i high, the block SHALL grant, latch wr_rd, addr and w_data of the winner into mem_*_o, set mem_valid_o=1 and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: a single requester wins; when both request, the port not equal to last_grant wins; last_grant SHALL update on every grant.
REQ-019 ISSUE SHALL last exactly one cycle, then clear mem_valid_o, clear the timeout counter and go to WAIT.
REQ-020 In WAIT with mem_ready_i=1, the block SHALL drive the granted p<n>_ready_o=1 with p<n>_err_o=0, load p<n>_r_data_o from mem_r_data_i on reads (value held on writes) and go to RESP.
REQ-021 In WAIT with mem_ready_i=0, the block SHALL increment the counter; when the counter reaches TIMEOUT, it SHALL drive ready_o=1, err_o=1 and r_data_o=0 on the granted port and go to RESP.
REQ-022 mem_ready_i and simultaneous ready/timeout SHALL resolve as success when both occur in the same WAIT cycle.
REQ-023 RESP SHALL last one cycle, clear ready_o and err_o, go to IDLE and ignore all valids.
REQ-024 Nominal latency SHALL be: valid sampled in IDLE at edge N, mem_valid_o high in cycle N+1, ready_o high in cycle N+3 (given memory ready one cycle after its valid), and a new grant no earlier than cycle N+4.
REQ-025 The non-granted port SHALL see ready_o=0 and its request SHALL wait, with no loss of the request while its valid stays high.
REQ-026 A requester dropping valid mid-transaction SHALL not abort it; the ready pulse SHALL still occur.
REQ-027 mem_ready_i outside WAIT SHALL be ignored.
REQ-028 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-029 rst_i=1 SHALL immediately, independent of clk_i, force state IDLE, all outputs 0, counter 0 and last_grant=1 (so port 0 wins the first tie).
REQ-030 Reset asserted mid-transaction SHALL drop it silently, with no ready pulse after release.

Verification
REQ-031 The bench SHALL cover a p0 write: addr=3, data=0xA5 -> mem_valid_o one cycle with addr 3 and data 0xA5, then p0_ready_o pulse at N+3 with err=0.
REQ-032 The bench SHALL cover a p1 read of addr 3 after that write: memory returns 0xA5 -> p1_r_data_o=0xA5 together with the p1_ready_o pulse.
REQ-033 The bench SHALL cover both ports requesting continuously after reset -> grants alternate 0,1,0,1, with exactly one ready per transaction.
REQ-034 The bench SHALL cover memory that never asserts ready, with TIMEOUT=15 -> ready_o=1, err_o=1 and r_data_o=0 exactly 15 WAIT cycles later, then IDLE.
REQ-035 The bench SHALL cover rst_i pulsed in WAIT -> outputs 0 immediately, no ready pulse, and the next tie granted to port 0.
REQ-036 The bench SHALL cover a spurious mem_ready_i in IDLE, and valid dropped during WAIT -> no state change for the first, and the ready pulse still delivered for the second.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin front end for one memory port; one transaction in flight, every output a flop.
// Request sampled at edge N: mem_valid_o in the following cycle, ready pulse two cycles later; losers hold valid and wait.
module mem_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  p0_valid_i,
  input  logic                  p0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [WIDTH-1:0]      p0_w_data_i,
  output logic                  p0_ready_o,
  output logic                  p0_err_o,
  output logic [WIDTH-1:0]      p0_r_data_o,

  input  logic                  p1_valid_i,
  input  logic                  p1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [WIDTH-1:0]      p1_w_data_i,
  output logic                  p1_ready_o,
  output logic                  p1_err_o,
  output logic [WIDTH-1:0]      p1_r_data_o,

  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_w_data_o,
  input  logic [WIDTH-1:0]      mem_r_data_i,
  input  logic                  mem_ready_i,

  output logic                  busy_o,
  output logic                  grant_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_w_data_q, mem_w_data_d;
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            err_q, err_d;
  logic [WIDTH-1:0]      p0_r_data_q, p0_r_data_d;
  logic [WIDTH-1:0]      p1_r_data_q, p1_r_data_d;
  logic                  win;

  // On a tie the port that did not win last time goes next.
  assign win = (p0_valid_i & p1_valid_i) ? ~last_grant_q : p1_valid_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_valid_d  = mem_valid_q;
    mem_wr_rd_d  = mem_wr_rd_q;
    mem_addr_d   = mem_addr_q;
    mem_w_data_d = mem_w_data_q;
    ready_d      = 2'b00;
    err_d        = 2'b00;
    p0_r_data_d  = p0_r_data_q;
    p1_r_data_d  = p1_r_data_q;

    unique case (state_q)
      IDLE: begin
        if (p0_valid_i | p1_valid_i) begin
          grant_d      = win;
          last_grant_d = win;
          mem_valid_d  = 1'b1;
          mem_wr_rd_d  = win ? p1_wr_rd_i  : p0_wr_rd_i;
          mem_addr_d   = win ? p1_addr_i   : p0_addr_i;
          mem_w_data_d = win ? p1_w_data_i : p0_w_data_i;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        // A memory response in the same cycle as the timeout wins.
        if (mem_ready_i) begin
          ready_d[grant_q] = 1'b1;
          if (!mem_wr_rd_q) begin
            if (grant_q) p1_r_data_d = mem_r_data_i;
            else         p0_r_data_d = mem_r_data_i;
          end
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d            = CNT_MAX;
          ready_d[grant_q] = 1'b1;
          err_d[grant_q]   = 1'b1;
          if (grant_q) p1_r_data_d = '0;
          else         p0_r_data_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_wr_rd_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      ready_q      <= 2'b00;
      err_q        <= 2'b00;
      p0_r_data_q  <= '0;
      p1_r_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      mem_valid_q  <= mem_valid_d;
      mem_wr_rd_q  <= mem_wr_rd_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      p0_r_data_q  <= p0_r_data_d;
      p1_r_data_q  <= p1_r_data_d;
    end
  end

  assign p0_ready_o   = ready_q[0];
  assign p1_ready_o   = ready_q[1];
  assign p0_err_o     = err_q[0];
  assign p1_err_o     = err_q[1];
  assign p0_r_data_o  = p0_r_data_q;
  assign p1_r_data_o  = p1_r_data_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_wr_rd_o  = mem_wr_rd_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_w_data_o = mem_w_data_q;
  assign busy_o       = busy_q;
  assign grant_o      = grant_q;

endmodule
